// File: rtl/lcd_seq_ctrl.sv
// HD44780-style LCD transfer sequencer: {rs,data} FIFO plus setup / EN-pulse / hold / exec timing.
// Define LCD_INIT_SEQ_EN to add the power-up delay and the built-in init ROM sequence.
module lcd_seq_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int T_SETUP    = 2,
  parameter int T_PW       = 12,
  parameter int T_HOLD     = 2,
  parameter int T_EXEC     = 2000,
  parameter int T_LONG     = 80000,
  parameter int T_PWRUP    = 2000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rs,
  input  logic [7:0]                    cmd_data,
  input  logic                          flush,
  output logic [31:0]                   lcd_word,
  output logic                          busy,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_SETUP, T_PW), max2(T_HOLD, T_EXEC)),
                              max2(T_LONG, T_PWRUP));
  localparam int CW = $clog2(T_MAX) + 1;

  typedef enum logic [2:0] {
`ifdef LCD_INIT_SEQ_EN
    S_PWRUP = 3'd0,
    S_INIT  = 3'd1,
`endif
    S_IDLE  = 3'd2,
    S_SETUP = 3'd3,
    S_PULSE = 3'd4,
    S_HOLD  = 3'd5,
    S_EXEC  = 3'd6
  } state_t;

  function automatic logic [CW-1:0] lim(input int t);
    return CW'(t - 1);
  endfunction

`ifdef LCD_INIT_SEQ_EN
  function automatic logic [7:0] init_rom(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  logic [1:0] idx_q, idx_d;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            work_rs_q, work_rs_d;
  logic [7:0]      work_data_q, work_data_d;
  logic            en_q, en_d;
  logic            rs_out_q, rs_out_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            on_q, on_d;
  logic            init_done_q, init_done_d;

  logic [8:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;

  logic            push, pop, empty, full, exec_long;
  logic [8:0]      head;

  assign empty     = (count_q == '0);
  assign full      = (count_q == LW'(FIFO_DEPTH));
  assign cmd_ready = on_q && !full;
  assign push      = cmd_valid && cmd_ready && !flush;
  assign head      = mem_q[rd_ptr_q];
  assign exec_long = !work_rs_q && (work_data_q == 8'h01 || work_data_q == 8'h02 ||
                                    work_data_q == 8'h03);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    work_rs_d   = work_rs_q;
    work_data_d = work_data_q;
    on_d        = 1'b1;
`ifdef LCD_INIT_SEQ_EN
    idx_d       = idx_q;
    init_done_d = init_done_q;
`else
    init_done_d = 1'b1;
`endif
    pop         = 1'b0;
    // Pins follow the state one cycle late, so RS/DATA lead EN by exactly T_SETUP cycles.
    en_d        = (state_q == S_PULSE);
    rs_out_d    = (state_q == S_SETUP) ? work_rs_q   : rs_out_q;
    data_out_d  = (state_q == S_SETUP) ? work_data_q : data_out_q;

    case (state_q)
`ifdef LCD_INIT_SEQ_EN
      S_PWRUP: begin
        if (cnt_q == lim(T_PWRUP)) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      S_INIT: begin
        work_rs_d   = 1'b0;
        work_data_d = init_rom(idx_q);
        state_d     = S_SETUP;
        cnt_d       = '0;
      end
`endif
      S_IDLE: begin
        cnt_d = '0;
        if (init_done_q && !empty) begin
          pop         = 1'b1;
          work_rs_d   = head[8];
          work_data_d = head[7:0];
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == lim(T_SETUP)) begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end
      end
      S_PULSE: begin
        if (cnt_q == lim(T_PW)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q == lim(T_HOLD)) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end
      end
      S_EXEC: begin
        if (cnt_q == (exec_long ? lim(T_LONG) : lim(T_EXEC))) begin
          state_d = S_IDLE;
          cnt_d   = '0;
`ifdef LCD_INIT_SEQ_EN
          if (!init_done_q) begin
            if (idx_q == 2'd3) begin
              init_done_d = 1'b1;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = S_INIT;
            end
          end
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush wins over any push or pop in the same cycle; the popped head still runs.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef LCD_INIT_SEQ_EN
      state_q <= S_PWRUP;
      idx_q   <= 2'd0;
`else
      state_q <= S_IDLE;
`endif
      cnt_q       <= '0;
      work_rs_q   <= 1'b0;
      work_data_q <= 8'h00;
      en_q        <= 1'b0;
      rs_out_q    <= 1'b0;
      data_out_q  <= 8'h00;
      on_q        <= 1'b0;
      init_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
`ifdef LCD_INIT_SEQ_EN
      idx_q       <= idx_d;
`endif
      cnt_q       <= cnt_d;
      work_rs_q   <= work_rs_d;
      work_data_q <= work_data_d;
      en_q        <= en_d;
      rs_out_q    <= rs_out_d;
      data_out_q  <= data_out_d;
      on_q        <= on_d;
      init_done_q <= init_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 9'h000;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {cmd_rs, cmd_data};
    end
  end

  assign lcd_word   = {on_q, 20'b0, en_q, rs_out_q, 1'b0, data_out_q};
  assign busy       = (state_q != S_IDLE) || !empty;
  assign init_done  = init_done_q;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed bench for lcd_seq_ctrl; expectations follow LCD_INIT_SEQ_EN if it is defined.
module tb_lcd_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rs;
  logic [7:0]  cmd_data;
  logic        flush;
  logic [31:0] lcd_word;
  logic        busy;
  logic        init_done;
  logic [2:0]  fifo_level;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;

  lcd_seq_ctrl #(
    .FIFO_DEPTH(4), .T_SETUP(2), .T_PW(4), .T_HOLD(2),
    .T_EXEC(10), .T_LONG(40), .T_PWRUP(20)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .flush(flush), .lcd_word(lcd_word),
    .busy(busy), .init_done(init_done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Waits (bounded) for EN to reach level; 'at' is the cycle count since the last reset release.
  task automatic wait_en(input logic level, input int limit, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (lcd_word[10] === level) begin
        ok = 1'b1;
        at = cyc - t0;
        break;
      end
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    t0  = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00; flush = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (lcd_word !== 32'h0) begin n_err++; $display("FAIL reset_word: got %h expected %h", lcd_word, 32'h0); end
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
  endtask

  task automatic push_part();
    logic [8:0] pv[$];
    bit         pr[$];
`ifdef LCD_INIT_SEQ_EN
    pv = '{9'h130, 9'h131, 9'h132, 9'h133, 9'h134};
    pr = '{1, 1, 1, 1, 0};
`else
    pv = '{9'h001, 9'h130, 9'h131, 9'h132, 9'h133, 9'h134};
    pr = '{1, 1, 1, 1, 1, 0};
`endif
    n_cmp++; if (lcd_word !== 32'h0) begin n_err++; $display("FAIL on_before_edge: got %h expected %h", lcd_word, 32'h0); end
    @(negedge clk);
    n_cmp++; if (lcd_word !== 32'h8000_0000) begin n_err++; $display("FAIL on_first_edge: got %h expected %h", lcd_word, 32'h8000_0000); end
`ifdef LCD_INIT_SEQ_EN
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL init_done_early: got %b expected 0", init_done); end
`else
    n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL init_done_first_edge: got %b expected 1", init_done); end
`endif
    for (int i = 0; i < pv.size(); i++) begin
      cmd_valid = 1'b1;
      {cmd_rs, cmd_data} = pv[i];
      n_cmp++;
      if (cmd_ready !== pr[i]) begin n_err++; $display("FAIL ready_push%0d: got %b expected %b", i, cmd_ready, pr[i]); end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d expected 4", fifo_level); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", cmd_ready); end
  endtask

  task automatic drain_part();
    logic [8:0]  xr[$];
    int          gaps[$];
    int          first, rise, fall, last_fall;
    bit          ok;
    logic [31:0] ew;
`ifdef LCD_INIT_SEQ_EN
    xr    = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h130, 9'h131, 9'h132, 9'h133};
    gaps  = '{0, 15, 15, 45, 15, 15, 15, 15};
    first = 24;
`else
    xr    = '{9'h001, 9'h130, 9'h131, 9'h132, 9'h133};
    gaps  = '{0, 45, 15, 15, 15};
    first = 6;
`endif
    last_fall = 0;
    for (int i = 0; i < xr.size(); i++) begin
      wait_en(1'b1, 200, rise, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL xfer%0d_rise_timeout: got none expected EN", i); end
      n_cmp++;
      if (rise !== ((i == 0) ? first : last_fall + gaps[i])) begin
        n_err++; $display("FAIL xfer%0d_rise_cycle: got %0d expected %0d", i, rise, (i == 0) ? first : last_fall + gaps[i]);
      end
      ew = {1'b1, 20'b0, 1'b1, xr[i][8], 1'b0, xr[i][7:0]};
      n_cmp++; if (lcd_word !== ew) begin n_err++; $display("FAIL xfer%0d_word: got %h expected %h", i, lcd_word, ew); end
      wait_en(1'b0, 50, fall, ok);
      n_cmp++; if (!ok || (fall - rise) !== 4) begin n_err++; $display("FAIL xfer%0d_en_width: got %0d expected 4", i, fall - rise); end
      last_fall = fall;
`ifdef LCD_INIT_SEQ_EN
      if (i == 3) begin
        repeat (10) @(negedge clk);
        n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL init_done_pre: got %b expected 0", init_done); end
        @(negedge clk);
        n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL init_done_set: got %b expected 1", init_done); end
      end
`endif
    end
    repeat (10) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL drain_busy_exec: got %b expected 1", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drain_busy_idle: got %b expected 0", busy); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL drain_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_fifo_full_drain();
    release_rst();
    fork
      push_part();
      drain_part();
    join
  endtask

  task automatic test_single_write();
    logic [31:0] ew;
    logic        exp_en, exp_busy;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h41;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      exp_en   = (k >= 4) && (k < 8);
      exp_busy = (k < 19);
      ew = {1'b1, 20'b0, exp_en, 1'b1, 1'b0, (k >= 2) ? 8'h41 : 8'h33};
      n_cmp++; if (lcd_word !== ew) begin n_err++; $display("FAIL single_word_k%0d: got %h expected %h", k, lcd_word, ew); end
      n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL single_busy_k%0d: got %b expected %b", k, busy, exp_busy); end
    end
  endtask

  task automatic test_flush();
    int ke, fall, rise;
    bit ok;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h51;
    @(negedge clk);
    ke = cyc - t0;
    cmd_data = 8'h52;
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL flush_level_k0: got %0d expected 1", fifo_level); end
    @(negedge clk);
    cmd_data = 8'h53;
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL flush_level_pushpop: got %0d expected 1", fifo_level); end
    @(negedge clk);
    cmd_data = 8'h54;
    @(negedge clk);
    n_cmp++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL flush_level_k3: got %0d expected 3", fifo_level); end
    cmd_data = 8'h55;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; cmd_valid = 1'b0;
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL flush_level_after: got %0d expected 0", fifo_level); end
    n_cmp++; if (lcd_word !== 32'h8000_0651) begin n_err++; $display("FAIL flush_pulse_word: got %h expected %h", lcd_word, 32'h8000_0651); end
    wait_en(1'b0, 20, fall, ok);
    n_cmp++; if (!ok || fall !== ke + 8) begin n_err++; $display("FAIL flush_en_fall: got %0d expected %0d", fall, ke + 8); end
    wait_en(1'b1, 60, rise, ok);
    n_cmp++; if (ok) begin n_err++; $display("FAIL flush_extra_pulse: got EN at %0d expected none", rise); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mid_reset();
    int rise;
    bit ok;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h61;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_en(1'b1, 20, rise, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL midrst_en_timeout: got none expected EN"); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (lcd_word !== 32'h0) begin n_err++; $display("FAIL midrst_word: got %h expected %h", lcd_word, 32'h0); end
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL midrst_init_done: got %b expected 0", init_done); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b expected 0", cmd_ready); end
    repeat (2) @(negedge clk);
    release_rst();
    @(negedge clk);
    n_cmp++; if (lcd_word !== 32'h8000_0000) begin n_err++; $display("FAIL midrst_on: got %h expected %h", lcd_word, 32'h8000_0000); end
`ifdef LCD_INIT_SEQ_EN
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL midrst_init_restart: got %b expected 0", init_done); end
    wait_en(1'b1, 100, rise, ok);
    n_cmp++; if (!ok || rise !== 24) begin n_err++; $display("FAIL midrst_first_rise: got %0d expected 24", rise); end
    n_cmp++; if (lcd_word !== 32'h8000_0438) begin n_err++; $display("FAIL midrst_first_word: got %h expected %h", lcd_word, 32'h8000_0438); end
`else
    n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL midrst_init_done_set: got %b expected 1", init_done); end
    wait_en(1'b1, 30, rise, ok);
    n_cmp++; if (ok) begin n_err++; $display("FAIL midrst_stale_pulse: got EN at %0d expected none", rise); end
`endif
  endtask

  initial begin
    test_reset();
    test_fifo_full_drain();
    test_single_write();
    test_flush();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
